regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/rwa_pkg.sv | 13 +
 rtl/rwa_decode.sv | 18 +
 rtl/regfile_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rwa_pkg.sv
// Shared constants and arbiter state type for the register-file write arbiter.
package rwa_pkg;

  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  // Records which requester won the most recent transfer.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } rwa_state_e;

endpackage : rwa_pkg

// File: rtl/rwa_decode.sv
// Register-number to one-hot write-enable decoder with an enable gate.
module rwa_decode
  import rwa_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  // One-hot decode of addr; all zeros when not enabled.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule : rwa_decode

// File: rtl/regfile_wr_arbiter.sv
// Two-port round-robin write arbiter in front of a 32-entry register file.
// Optional feature: define RWA_CONFLICT_STATS_EN to add the 16-bit saturating
// conflict_cnt output (cycles with both requests high and no stall).
//
// state  | meaning
// -------+-----------------------------------------------------------
// LAST_A | requester A won the last transfer; B wins the next conflict
// LAST_B | requester B won the last transfer (reset); A wins next
module regfile_wr_arbiter
  import rwa_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                req_a,
  input  logic                req_b,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   data_a,
  input  logic [DATA_W-1:0]   data_b,
  output logic                gnt_a,
  output logic                gnt_b,
  output logic [NUM_REGS-1:0] we,
`ifdef RWA_CONFLICT_STATS_EN
  output logic [15:0]         conflict_cnt,
`endif
  output logic [DATA_W-1:0]   wdata
);

  rwa_state_e            state_q, state_d;
  logic [NUM_REGS-1:0]   we_q, we_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  xfer;
  logic [ADDR_W-1:0]     gnt_addr;
  logic [DATA_W-1:0]     gnt_data;
  logic                  dec_en;

  // Grants, winner mux and next-state: round-robin only matters on conflict.
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    state_d  = state_q;
    gnt_addr = addr_a;
    gnt_data = data_a;
    if (!rst && !stall) begin
      if (req_a && req_b) begin
        gnt_a = (state_q == LAST_B);
        gnt_b = (state_q == LAST_A);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
    if (gnt_b) begin
      gnt_addr = addr_b;
      gnt_data = data_b;
    end
    if (gnt_a) begin
      state_d = LAST_A;
    end else if (gnt_b) begin
      state_d = LAST_B;
    end
  end

  assign xfer   = gnt_a | gnt_b;
  // Register 0 is hardwired; its transfers handshake but never write.
  assign dec_en = xfer && (gnt_addr != '0);

  rwa_decode u_decode (
    .en     (dec_en),
    .addr   (gnt_addr),
    .onehot (we_d)
  );

  // Write data follows the winner and is held on idle cycles.
  always_comb begin
    wdata_d = wdata_q;
    if (xfer) begin
      wdata_d = gnt_data;
    end
  end

  // Arbiter state and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LAST_B;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign we    = we_q;
  assign wdata = wdata_q;

`ifdef RWA_CONFLICT_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating count of unstalled cycles where both requesters contend.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (req_a && req_b && !stall && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule : regfile_wr_arbiter

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a write-port scoreboard.
// Build with RWA_CONFLICT_STATS_EN defined to also check conflict_cnt.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        req_a, req_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic        gnt_a, gnt_b;
  logic [31:0] we;
  logic [31:0] wdata;
`ifdef RWA_CONFLICT_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  regfile_wr_arbiter #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .req_a        (req_a),
    .req_b        (req_b),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .data_a       (data_a),
    .data_b       (data_b),
    .gnt_a        (gnt_a),
    .gnt_b        (gnt_b),
    .we           (we),
`ifdef RWA_CONFLICT_STATS_EN
    .conflict_cnt (conflict_cnt),
`endif
    .wdata        (wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] we;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        m_last_b;   // 1: B won last (A wins next conflict)
  logic [31:0] m_wdata;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_b = 1'b1;
    m_wdata  = '0;
    m_cnt    = '0;
    sb.delete();
  endtask

  // One clock of stimulus: check grants combinationally, push the expected
  // write-port values, then pop and compare them one edge later.
  task automatic step(input string tag, input logic ra, input logic rb,
                      input logic [4:0] aa, input logic [4:0] ab,
                      input logic [31:0] da, input logic [31:0] db,
                      input logic st);
    logic   ega, egb;
    logic [4:0] ea;
    exp_t   e, got;
    req_a = ra; req_b = rb; addr_a = aa; addr_b = ab;
    data_a = da; data_b = db; stall = st;
    #1;
    ega = !st && ra && (!rb || m_last_b);
    egb = !st && rb && !ega;
    check({tag, ":gnt_a"}, {31'd0, gnt_a}, {31'd0, ega});
    check({tag, ":gnt_b"}, {31'd0, gnt_b}, {31'd0, egb});
    ea = ega ? aa : ab;
    if (ega || egb) m_wdata = ega ? da : db;
    e.we    = ((ega || egb) && ea != 5'd0) ? (32'd1 << ea) : 32'd0;
    e.wdata = m_wdata;
    sb.push_back(e);
    if (ega) m_last_b = 1'b0;
    if (egb) m_last_b = 1'b1;
    if (ra && rb && !st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s:scoreboard empty observed=0 expected=1", tag);
    end else begin
      got = sb.pop_front();
      check({tag, ":we"},    we,    got.we);
      check({tag, ":wdata"}, wdata, got.wdata);
    end
`ifdef RWA_CONFLICT_STATS_EN
    check({tag, ":conflict_cnt"}, {16'd0, conflict_cnt}, {16'd0, m_cnt});
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; req_a = 1'b0; req_b = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    model_reset();
    #2;
    check("reset:gnt_a", {31'd0, gnt_a}, 32'd0);
    check("reset:gnt_b", {31'd0, gnt_b}, 32'd0);
    check("reset:we",    we,    32'd0);
    check("reset:wdata", wdata, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention from reset: A, B, A, B.
    for (int i = 0; i < 4; i++)
      step("contend", 1, 1, 5'd3, 5'd5, 32'hA000_0000 + i, 32'hB000_0000 + i, 0);
`ifdef RWA_CONFLICT_STATS_EN
    check("contend:cnt4", {16'd0, conflict_cnt}, 32'd4);
`endif

    // Single requester, then address zero, then idle hold.
    step("single_a", 1, 0, 5'd7, 5'd0, 32'hDEAD_BEEF, 32'h0, 0);
    check("single_a:we7", we, 32'h0000_0080);
    step("addr0_b", 0, 1, 5'd0, 5'd0, 32'h0, 32'h0000_1234, 0);
    check("addr0_b:we0", we, 32'h0);
    step("idle", 0, 0, 5'd4, 5'd6, 32'h5555_5555, 32'h6666_6666, 0);

    // Stall blocks both; round-robin resumes from stored state (B last).
    for (int i = 0; i < 3; i++)
      step("stall", 1, 1, 5'd10, 5'd11, 32'h10, 32'h11, 1);
    step("resume1", 1, 1, 5'd10, 5'd11, 32'h10, 32'h11, 0);
    step("resume2", 1, 1, 5'd12, 5'd11, 32'h12, 32'h11, 0);

    // Same target from both sides: serialised, later write last.
    step("same1", 1, 1, 5'd9, 5'd9, 32'h111, 32'h222, 0);
    step("same2", 0, 1, 5'd9, 5'd9, 32'h111, 32'h222, 0);

    // Mixed traffic including the top register.
    for (int i = 0; i < 30; i++)
      step("mixed", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           $urandom, $urandom, ($urandom_range(0, 3) == 0));
    step("reg31", 1, 0, 5'd31, 5'd0, 32'hFFFF_0031, 32'h0, 0);

    // Reset mid-burst: back-to-back grants, then async reset.
    step("burst1", 1, 1, 5'd1, 5'd2, 32'hC1, 32'hC2, 0);
    step("burst2", 1, 1, 5'd1, 5'd2, 32'hC3, 32'hC4, 0);
    req_a = 1'b1; req_b = 1'b1; stall = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst:gnt_a", {31'd0, gnt_a}, 32'd0);
    check("midrst:gnt_b", {31'd0, gnt_b}, 32'd0);
    check("midrst:we",    we,    32'd0);
    check("midrst:wdata", wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step("post_rst1", 1, 1, 5'd4, 5'd8, 32'hD4, 32'hD8, 0);
    step("post_rst2", 1, 1, 5'd4, 5'd8, 32'hD4, 32'hD8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_wr_arbiter
